// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM state type and Funct3 encodings for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; ptr_i picks the winner only on contention
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);
  always_comb grant_o = (valid_i == 2'b11) ? (ptr_i ? 2'b10 : 2'b01) : valid_i;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-ported data memory
// Optional DMEM_ARB_STATS_EN adds per-port 32-bit grant counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*DM_ADDRESS-1:0] req_addr,
  input  logic [2*DATA_W-1:0]     req_wdata,
  input  logic [5:0]              req_funct3,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic [DM_ADDRESS-1:0]   a,
  output logic [DATA_W-1:0]       wd,
  output logic [2:0]              Funct3,
  input  logic [DATA_W-1:0]       rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]             grant_cnt0,
  output logic [31:0]             grant_cnt1
`endif
);
  state_e                  state_q;
  logic                    rr_ptr_q, owner_q, we_q;
  logic [DM_ADDRESS-1:0]   addr_q;
  logic [DATA_W-1:0]       wdata_q, rdata_q;
  logic [2:0]              f3_q;
  logic [1:0]              grant, accept;
  logic                    sel, acc;
  rr_arbiter2 u_arb (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );
  always_comb begin
    req_ready = (state_q == IDLE && !reset) ? grant : 2'b00;
    accept    = req_valid & req_ready;
    sel       = accept[1];
    acc       = state_q == ACCESS;
    // reset gates the strobes combinationally so an abandoned store never lands
    MemRead   = acc && !we_q && !reset;
    MemWrite  = acc && we_q && !reset;
    a         = acc ? addr_q : '0;
    wd        = acc ? wdata_q : '0;
    Funct3    = acc ? f3_q : 3'b000;
    rsp_valid = (state_q == RESP) ? {owner_q, ~owner_q} : 2'b00;
    rsp_rdata = rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= 3'b000;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (|accept) begin
          owner_q  <= sel;
          rr_ptr_q <= ~sel;
          we_q     <= sel ? req_we[1] : req_we[0];
          addr_q   <= sel ? req_addr[2*DM_ADDRESS-1:DM_ADDRESS] : req_addr[DM_ADDRESS-1:0];
          wdata_q  <= sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          f3_q     <= sel ? req_funct3[5:3] : req_funct3[2:0];
          state_q  <= ACCESS;
        end
        ACCESS: begin
          rdata_q <= we_q ? '0 : rd;
          state_q <= RESP;
        end
        RESP: if (rsp_ready[owner_q]) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] cnt0_q, cnt1_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (accept[0]) cnt0_q <= cnt0_q + 32'd1;
      if (accept[1]) cnt1_q <= cnt1_q + 32'd1;
    end
  end
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a word-addressed memory model
module tb_dmem_arbiter;
  logic        clk, reset;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [17:0] req_addr;
  logic [63:0] req_wdata;
  logic [5:0]  req_funct3;
  logic [31:0] rsp_rdata, wd, rd;
  logic        MemRead, MemWrite;
  logic [8:0]  a;
  logic [2:0]  Funct3;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1;
`endif
  dmem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .a          (a),
    .wd         (wd),
    .Funct3     (Funct3),
    .rd         (rd)
`ifdef DMEM_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );
  typedef struct {int port; logic [31:0] data;} exp_t;
  logic [31:0] mem [512];
  logic [31:0] ref_mem [512];
  exp_t        sb [$];
  int          grants [$];
  int          n_chk = 0, n_pass = 0;
  int          mp;
  logic [8:0]  mad;
  exp_t        me;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign rd = mem[a];
  always @(posedge clk) if (MemWrite) mem[a] = wd;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    if (reset) sb.delete();
    else begin
      if (|(req_valid & req_ready)) begin
        mp = req_ready[1] ? 1 : 0;
        mad = req_addr[mp*9 +: 9];
        me.port = mp;
        me.data = req_we[mp] ? 32'h0 : ref_mem[mad];
        if (req_we[mp]) ref_mem[mad] = req_wdata[mp*32 +: 32];
        sb.push_back(me);
        grants.push_back(mp);
      end
      if (|(rsp_valid & rsp_ready)) begin
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          me = sb.pop_front();
          check("rsp_port", {30'd0, rsp_valid}, me.port == 1 ? 32'd2 : 32'd1);
          check("rsp_data", rsp_rdata, me.data);
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int p, input logic we, input logic [8:0] ad, input logic [31:0] dat, input logic [2:0] f3);
    req_we[p] = we;
    req_addr[p*9 +: 9] = ad;
    req_wdata[p*32 +: 32] = dat;
    req_funct3[p*3 +: 3] = f3;
    req_valid[p] = 1'b1;
  endtask
  task automatic wait_ready(input int p);
    for (int i = 0; i < 20 && !req_ready[p]; i++) tick();
    if (!req_ready[p]) check("ready_timeout", 32'd0, 32'd1);
  endtask
  task automatic do_txn(input int p, input logic we, input logic [8:0] ad, input logic [31:0] dat);
    set_req(p, we, ad, dat, 3'b010);
    #1;
    wait_ready(p);
    tick();
    req_valid[p] = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid[p]; i++) tick();
    if (!rsp_valid[p]) check("rsp_timeout", 32'd0, 32'd1);
    tick();
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = 32'h5555_5555;
      ref_mem[i] = 32'h5555_5555;
    end
    mem[9'h010] = 32'hDEAD_BEEF;
    ref_mem[9'h010] = 32'hDEAD_BEEF;
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    rsp_ready = 2'b11;
    reset = 1'b1;
    tick();
    req_valid = 2'b01;
    #1;
    check("ready_in_reset", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    tick();
    reset = 1'b0;
    #1;
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_memctl", {30'd0, MemRead, MemWrite}, 32'd0);
    check("rst_a_wd_f3", {20'd0, a, Funct3}, 32'd0);
    // single load timing
    set_req(0, 1'b0, 9'h010, 32'h0, 3'b010);
    #1;
    check("ld_ready_c0", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    check("ld_memread_c1", {31'd0, MemRead}, 32'd1);
    check("ld_memwrite_c1", {31'd0, MemWrite}, 32'd0);
    check("ld_addr_c1", {23'd0, a}, 32'h010);
    check("ld_f3_c1", {29'd0, Funct3}, 32'd2);
    tick();
    check("ld_rsp_valid_c2", {30'd0, rsp_valid}, 32'd1);
    check("ld_rdata_c2", rsp_rdata, 32'hDEAD_BEEF);
    check("ld_memread_c2", {31'd0, MemRead}, 32'd0);
    tick();
    check("ld_rsp_done", {30'd0, rsp_valid}, 32'd0);
    // port-1 store then load
    set_req(1, 1'b1, 9'h020, 32'h1234_5678, 3'b010);
    #1;
    check("st_ready", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    check("st_memwrite_c1", {31'd0, MemWrite}, 32'd1);
    check("st_wd_c1", wd, 32'h1234_5678);
    check("st_addr_c1", {23'd0, a}, 32'h020);
    tick();
    check("st_memwrite_c2", {31'd0, MemWrite}, 32'd0);
    check("st_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    check("st_rdata_zero", rsp_rdata, 32'd0);
    tick();
    check("st_mem", mem[9'h020], 32'h1234_5678);
    do_txn(1, 1'b0, 9'h020, 32'h0);
    // contention from reset
    do_reset();
    grants.delete();
    set_req(0, 1'b0, 9'h010, 32'h0, 3'b010);
    set_req(1, 1'b0, 9'h020, 32'h0, 3'b010);
    for (int i = 0; i < 40 && grants.size() < 4; i++) tick();
    req_valid = 2'b00;
    check("cont_count", grants.size(), 32'd4);
    for (int k = 0; k < 4 && k < grants.size(); k++) check("cont_order", grants[k], k % 2);
    repeat (5) tick();
    // response backpressure, non-owner rsp_ready ignored
    rsp_ready = 2'b10;
    set_req(0, 1'b0, 9'h010, 32'h0, 3'b000);
    #1;
    wait_ready(0);
    tick();
    req_valid = 2'b00;
    tick();
    set_req(1, 1'b0, 9'h020, 32'h0, 3'b010);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
      check("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("bp_req_ready", {30'd0, req_ready}, 32'd0);
      check("bp_memctl", {30'd0, MemRead, MemWrite}, 32'd0);
      tick();
    end
    rsp_ready = 2'b11;
    #1;
    wait_ready(1);
    tick();
    req_valid = 2'b00;
    repeat (3) tick();
    // reset during a store access
    set_req(0, 1'b1, 9'h030, 32'hCAFE_F00D, 3'b010);
    #1;
    wait_ready(0);
    tick();
    req_valid = 2'b00;
    reset = 1'b1;
    #1;
    check("rst_acc_memwrite", {31'd0, MemWrite}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_acc_mem", mem[9'h030], 32'h5555_5555);
    check("rst_acc_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_acc_rdata", rsp_rdata, 32'd0);
    check("rst_acc_a", {23'd0, a}, 32'd0);
    check("rst_acc_memread", {31'd0, MemRead}, 32'd0);
`ifdef DMEM_ARB_STATS_EN
    do_txn(0, 1'b0, 9'h010, 32'h0);
    do_txn(1, 1'b0, 9'h020, 32'h0);
    do_txn(0, 1'b0, 9'h010, 32'h0);
    do_txn(1, 1'b0, 9'h020, 32'h0);
    do_txn(0, 1'b0, 9'h010, 32'h0);
    check("cnt0", grant_cnt0, 32'd3);
    check("cnt1", grant_cnt1, 32'd2);
    do_reset();
    #1;
    check("cnt0_rst", grant_cnt0, 32'd0);
    check("cnt1_rst", grant_cnt1, 32'd0);
`endif
    tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported data memory (`datamemory`).
- Port 0 is the core load/store path; port 1 is a secondary master (debug/DMA loader).
- Accepts one request at a time via valid/ready, drives `MemRead`/`MemWrite`/`a`/`wd`/`Funct3` for one access cycle, then returns read data (or a write ack) to the owning requester via a held response handshake.

Parameters:
- DM_ADDRESS, 9, memory address width (matches `datamemory`).
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port request accept.
- req_we  in  2  1 = store, 0 = load.
- req_addr  in  2*DM_ADDRESS  port i address at [i*DM_ADDRESS +: DM_ADDRESS].
- req_wdata  in  2*DATA_W  store data, packed as above.
- req_funct3  in  6  Funct3 per port, packed 3 bits each.
- rsp_valid  out  2  response valid to port i.
- rsp_ready  in  2  port i consumes response.
- rsp_rdata  out  DATA_W  load data (shared; qualified by rsp_valid).
- MemRead  out  1  to `datamemory`.
- MemWrite  out  1  to `datamemory`.
- a  out  DM_ADDRESS  to `datamemory`.
- wd  out  DATA_W  to `datamemory`.
- Funct3  out  3  to `datamemory`.
- rd  in  DATA_W  from `datamemory`.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (sync, active-high):
  - state=IDLE, rr_ptr=0, owner=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, MemRead=MemWrite=0, a=0, wd=0, Funct3=0.
- Grant (combinational, IDLE only):
  - If only one req_valid is set, grant that port.
  - If both are set, grant port rr_ptr.
  - req_ready[i] = (state==IDLE) && grant[i] && !reset. At most one bit is ever high.
- IDLE, on accept (valid&ready):
  - Latch owner, we, addr, wdata, funct3.
  - rr_ptr <= ~owner.
  - Next state = ACCESS.
- ACCESS (exactly 1 cycle):
  - MemRead = !we_q, MemWrite = we_q; a, wd, Funct3 from latched regs.
  - At the end of the cycle, capture rd into rsp_rdata when the access is a load; capture 0 when it is a store.
  - Next state = RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_rdata stable.
  - Hold until rsp_ready[owner], then go to IDLE.
  - rsp_ready on the non-owner port is ignored.
- Memory control outputs are 0 in IDLE and RESP.
- Latency: accept at edge N; memory access in cycle N+1; rsp_valid from cycle N+2. Minimum 3 cycles per transaction; no overlap.
- Requests arriving while not IDLE see req_ready=0 and must hold (no drop).
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1…; max wait is one transaction.
- Reset mid-operation:
  - Any transaction is abandoned with no response.
  - MemWrite/MemRead are forced to 0 combinationally in any cycle with reset high, so no partial write occurs.
- Funct3 and address are passed through unmodified; alignment and sub-word handling stay in `datamemory`.

Optional Feature:
- DMEM_ARB_STATS_EN defined: adds outputs grant_cnt0 and grant_cnt1 (32 bits each).
  - Each counter increments on every accepted request of its port.
  - Cleared by reset; wraps 0xFFFFFFFF -> 0.
- Undefined: no counters and no extra ports.

Decomposition:
- Package dmem_arb_pkg: state enum (IDLE, ACCESS, RESP), funct3 constants F3_LB=3'b000, F3_LH=3'b001, F3_LW=3'b010, F3_LBU=3'b100.
- One natural sub-module: rr_arbiter2 (2-way round-robin grant from valid vector + rr_ptr); everything else lives in dmem_arbiter.

Test Plan:
- Single load: port0 valid, we=0, addr=0x010, funct3=010, memory word 0xDEADBEEF -> req_ready[0] in cycle 0; MemRead=1, a=0x010 in cycle 1; rsp_valid[0]=1, rsp_rdata=0xDEADBEEF from cycle 2.
- Store then load: port1 stores 0x12345678 to 0x020 -> MemWrite=1 for exactly 1 cycle, rsp_rdata=0; port1 loads 0x020 -> 0x12345678.
- Contention: both ports valid continuously for 4 transactions from reset -> grant order 0,1,0,1; each response goes only to its owner.
- Response backpressure: hold rsp_ready[0]=0 for 5 cycles -> rsp_valid[0] and rsp_rdata stable; req_ready=0 on both ports; no memory access.
- Reset in ACCESS on a store -> MemWrite=0 that cycle, memory unchanged, all outputs at reset values next cycle.
- With DMEM_ARB_STATS_EN: 3 port-0 and 2 port-1 transactions -> grant_cnt0=3, grant_cnt1=2; reset -> both 0.
